sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//   Single-clock, parametrised FIFO; successor to the fixed 32x96 buffer.
//   Any DEPTH >= 2, no wasted slot at pointer wrap, occupancy count,
//   programmable almost-full/almost-empty, sticky overflow/underflow, sync flush.
//   Sits between a producer and consumer in the same clock domain.
// PARAMETERS
//   DATA_W    32   data width in bits
//   DEPTH     96   number of entries; any integer >= 2, not necessarily a power of 2
//   AF_LEVEL  88   almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  8    almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//   localparam PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1)
// PORTS
//   clk           in   1       clock; all state changes on rising edge
//   rst           in   1       asynchronous reset, active-high
//   din           in   DATA_W  write data
//   wr_en         in   1       write request
//   rd_en         in   1       read request
//   flush         in   1       synchronous clear of contents
//   clr_err       in   1       synchronous clear of sticky error flags
//   dout          out  DATA_W  read data
//   full          out  1       count == DEPTH
//   empty         out  1       count == 0
//   almost_full   out  1       count >= AF_LEVEL
//   almost_empty  out  1       count <= AE_LEVEL
//   count         out  CNT_W   current occupancy 0..DEPTH
//   overflow      out  1       sticky: write requested while full
//   underflow     out  1       sticky: read requested while empty
// BEHAVIOUR
//   - Reset (async): wr_ptr=rd_ptr=0, count=0, dout=0, overflow=underflow=0;
//     hence empty=1, full=0, almost_empty=1, almost_full=0. Memory is not cleared.
//   - wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty; both from pre-edge state.
//   - Write: mem[wr_ptr] <= din; wr_ptr increments, wraps DEPTH-1 -> 0.
//   - Read: rd_ptr increments, wraps DEPTH-1 -> 0.
//   - count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
//   - full, empty, almost_* decoded combinationally from count.
//   - Full + wr_en + rd_en: read accepted, write rejected, overflow set; count -> DEPTH-1.
//   - Empty + wr_en + rd_en: write accepted, read rejected, underflow set; count -> 1.
//   - Sticky flags: set on a rejected request; cleared by clr_err. Set has
//     priority over clr_err in the same cycle.
//   - flush: next edge ptrs=0, count=0. Overrides wr_en/rd_en in that cycle
//     (no write, no error). dout and error flags unchanged.
//   - Reset mid-operation discards all contents immediately; no partial update.
//   - Mem is written only on wr_acc; unaccepted din is never stored.
// CONFIGURATION
//   FIFO_FWFT_EN undefined (standard): dout registered; on rd_acc,
//     dout <= mem[rd_ptr] at that edge (1-cycle latency). dout holds otherwise.
//   FIFO_FWFT_EN defined (first-word fall-through): dout = mem[rd_ptr]
//     combinationally. Head word is valid whenever empty=0; rd_acc pops it.
//     A write into an empty FIFO appears on dout the cycle after the write edge.
//     dout is don't-care while empty. Flags, count and errors are identical in both modes.
// TESTING
//   1 Reset, write 0x0..0x5F (96 words) -> full=1 after the 96th, count=96,
//     almost_full from the 88th write; write 97 -> overflow=1, count stays 96.
//   2 Drain all 96 -> data 0x0..0x5F in order (std: 1-cycle latency; FWFT: head
//     visible). Then empty=1; extra rd_en -> underflow=1.
//   3 Wrap: DEPTH=5, 3 wr/3 rd, then 4 wr -> pointers wrap, order kept, count=4.
//   4 Simultaneous wr_en+rd_en at count=40 for 10 cycles -> count stays 40,
//     data ordering preserved; at full -> count 95, overflow=1; at empty -> count 1, underflow=1.
//   5 flush with wr_en=1 at count=50 -> count=0, empty=1, no store, no error;
//     clr_err -> overflow=underflow=0.
//   6 Assert rst asynchronously mid-burst (between edges) -> count=0, empty=1,
//     dout=0 immediately; after release the next write is read back first.

Source files
------------

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock parametrised FIFO for a producer and a consumer that share one
//   clock domain. Any DEPTH >= 2 (power of two or not) is supported, with every
//   slot usable: the pointers wrap explicitly at DEPTH-1. The FIFO provides an
//   occupancy count, programmable almost-full/almost-empty flags, sticky
//   overflow/underflow flags and a synchronous flush.
//
//   Build option (macro FIFO_FWFT_EN):
//     undefined : standard mode. dout is registered and loads the head word on
//                 an accepted read, so data appears one cycle after the read.
//     defined   : first-word fall-through. dout shows the head word
//                 combinationally while the FIFO is not empty.
//
// Ports
//   clk           in   clock; all state changes on the rising edge
//   rst           in   asynchronous reset, active-high
//   din           in   write data (DATA_W)
//   wr_en         in   write request
//   rd_en         in   read request
//   flush         in   synchronous clear of contents (pointers and count)
//   clr_err       in   synchronous clear of the sticky error flags
//   dout          out  read data (DATA_W)
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  occupancy 0..DEPTH (CNT_W)
//   overflow      out  sticky: write requested while full
//   underflow     out  sticky: read requested while empty
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 96,
    parameter  int AF_LEVEL = 88,
    parameter  int AE_LEVEL = 8,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              flush,
    input  logic              clr_err,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic wr_acc, rd_acc;
    logic wr_rej, rd_rej;

    // Status flags are pure decodes of the occupancy count.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Flush wins over both requests: nothing is stored, popped or flagged.
    assign wr_acc = wr_en & ~full  & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;
    assign wr_rej = wr_en & full   & ~flush;
    assign rd_rej = rd_en & empty  & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Explicit wrap keeps all DEPTH slots usable for any DEPTH.
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // A new rejected request takes priority over a same-cycle clear.
        if (wr_rej) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end
        if (rd_rej) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word falls through; meaningful only while empty is low.
    assign dout = mem_q[rd_ptr_q];
`else
    logic [DATA_W-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (rd_acc) begin
            dout_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//   Drives one shared stimulus stream into two FIFOs (DEPTH=96 and DEPTH=5)
//   and compares every output after each clock edge against a queue-based
//   reference model of the FIFO's documented behaviour.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        wr_en, rd_en, flush, clr_err;

    logic [31:0] dout0, dout1;
    logic        full0, empty0, af0, ae0, ovf0, udf0;
    logic        full1, empty1, af1, ae1, ovf1, udf1;
    logic [6:0]  cnt0;
    logic [2:0]  cnt1;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(32), .DEPTH(96), .AF_LEVEL(88), .AE_LEVEL(8)) u_big (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .clr_err(clr_err), .dout(dout0), .full(full0),
        .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_param #(.DATA_W(32), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_small (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .clr_err(clr_err), .dout(dout1), .full(full1),
        .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(udf1)
    );

    // Observed outputs gathered per instance.
    logic [31:0] o_dout [2];
    logic [31:0] o_cnt  [2];
    logic        o_full [2], o_empty [2], o_af [2], o_ae [2], o_ovf [2], o_udf [2];

    assign o_dout[0] = dout0;       assign o_dout[1] = dout1;
    assign o_cnt[0]  = 32'(cnt0);   assign o_cnt[1]  = 32'(cnt1);
    assign o_full[0] = full0;       assign o_full[1] = full1;
    assign o_empty[0] = empty0;     assign o_empty[1] = empty1;
    assign o_af[0]   = af0;         assign o_af[1]   = af1;
    assign o_ae[0]   = ae0;         assign o_ae[1]   = ae1;
    assign o_ovf[0]  = ovf0;        assign o_ovf[1]  = ovf1;
    assign o_udf[0]  = udf0;        assign o_udf[1]  = udf1;

    // Reference model state.
    int          mdepth [2] = '{96, 5};
    int          maf    [2] = '{88, 4};
    int          mae    [2] = '{8, 1};
    logic [31:0] mq     [2][$];
    logic        movf   [2];
    logic        mudf   [2];
    logic [31:0] mdout  [2];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            movf[i]  = 1'b0;
            mudf[i]  = 1'b0;
            mdout[i] = '0;
        end
    endtask

    // One rising edge of the model, using the currently driven inputs.
    task automatic model_step(input int i);
        int          sz;
        bit          is_full, is_empty, wa, ra;
        logic [31:0] popped;
        sz       = mq[i].size();
        is_full  = (sz == mdepth[i]);
        is_empty = (sz == 0);
        if (!flush && wr_en && is_full)       movf[i] = 1'b1;
        else if (clr_err)                     movf[i] = 1'b0;
        if (!flush && rd_en && is_empty)      mudf[i] = 1'b1;
        else if (clr_err)                     mudf[i] = 1'b0;
        if (flush) begin
            mq[i].delete();
        end else begin
            wa = wr_en && !is_full;
            ra = rd_en && !is_empty;
            if (ra) begin
                popped = mq[i].pop_front();
`ifndef FIFO_FWFT_EN
                mdout[i] = popped;
`endif
            end
            if (wa) mq[i].push_back(din);
        end
    endtask

    task automatic check_all();
        int sz;
        for (int i = 0; i < 2; i++) begin
            sz = mq[i].size();
            check($sformatf("d%0d.count", i), o_cnt[i], 32'(sz));
            check($sformatf("d%0d.full", i), 32'(o_full[i]), 32'(sz == mdepth[i]));
            check($sformatf("d%0d.empty", i), 32'(o_empty[i]), 32'(sz == 0));
            check($sformatf("d%0d.almost_full", i), 32'(o_af[i]), 32'(sz >= maf[i]));
            check($sformatf("d%0d.almost_empty", i), 32'(o_ae[i]), 32'(sz <= mae[i]));
            check($sformatf("d%0d.overflow", i), 32'(o_ovf[i]), 32'(movf[i]));
            check($sformatf("d%0d.underflow", i), 32'(o_udf[i]), 32'(mudf[i]));
`ifdef FIFO_FWFT_EN
            if (sz != 0) check($sformatf("d%0d.dout", i), o_dout[i], mq[i][0]);
`else
            check($sformatf("d%0d.dout", i), o_dout[i], mdout[i]);
`endif
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next.
    task automatic cycle(input logic w, input logic r, input logic [31:0] d,
                         input logic f, input logic c);
        wr_en = w; rd_en = r; din = d; flush = f; clr_err = c;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    int pw;

    initial begin
        rst = 1'b1; din = '0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        model_reset();
        #12;
        check_all();
        rst = 1'b0;

        // Fill the big FIFO with 0x00..0x5F, then one write too many.
        for (int k = 0; k < 96; k++) cycle(1'b1, 1'b0, 32'(k), 1'b0, 1'b0);
        check("t1.count96", o_cnt[0], 32'd96);
        check("t1.full", 32'(o_full[0]), 32'd1);
        cycle(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("t1.overflow", 32'(o_ovf[0]), 32'd1);
        check("t1.count_hold", o_cnt[0], 32'd96);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Drain everything, then one read too many.
        for (int k = 0; k < 96; k++) cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
`ifndef FIFO_FWFT_EN
        check("t2.last_word", o_dout[0], 32'h5F);
`endif
        cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        check("t2.underflow", 32'(o_udf[0]), 32'd1);
        check("t2.empty", 32'(o_empty[0]), 32'd1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Pointer wrap: 3 writes, 3 reads, 4 writes.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'h100 + 32'(k), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 32'h200 + 32'(k), 1'b0, 1'b0);
        check("t3.small_count4", o_cnt[1], 32'd4);

        // Simultaneous read/write at 40, at full and at empty.
        for (int k = 0; k < 36; k++) cycle(1'b1, 1'b0, 32'h300 + 32'(k), 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b1, 32'h400 + 32'(k), 1'b0, 1'b0);
        check("t4.count40", o_cnt[0], 32'd40);
        for (int k = 0; k < 56; k++) cycle(1'b1, 1'b0, 32'h500 + 32'(k), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h600, 1'b0, 1'b0);
        check("t4.full_rw_count", o_cnt[0], 32'd95);
        check("t4.full_rw_ovf", 32'(o_ovf[0]), 32'd1);
        for (int k = 0; k < 95; k++) cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h700, 1'b0, 1'b0);
        check("t4.empty_rw_count", o_cnt[0], 32'd1);
        check("t4.empty_rw_udf", 32'(o_udf[0]), 32'd1);
        cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

        // Flush with a concurrent write, then clear the sticky flags.
        for (int k = 0; k < 50; k++) cycle(1'b1, 1'b0, 32'h800 + 32'(k), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'hBAD0_0000, 1'b1, 1'b0);
        check("t5.flush_count", o_cnt[0], 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t5.clr_ovf", 32'(o_ovf[0]), 32'd0);
        check("t5.clr_udf", 32'(o_udf[0]), 32'd0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'h900 + 32'(k), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

        // Randomised phases biased towards filling, draining and mixing.
        for (int ph = 0; ph < 4; ph++) begin
            pw = (ph == 0) ? 80 : (ph == 1) ? 20 : (ph == 2) ? 60 : 45;
            for (int k = 0; k < 500; k++) begin
                cycle(1'($urandom_range(0, 99) < 32'(pw)),
                      1'($urandom_range(0, 99) < 32'(100 - pw)),
                      $urandom(),
                      1'($urandom_range(0, 63) == 0),
                      1'($urandom_range(0, 15) == 0));
            end
        end

        // Asynchronous reset in the middle of a write burst.
        for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 32'hA00 + 32'(k), 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        check("t6.rst_count", o_cnt[0], 32'd0);
        check("t6.rst_empty", 32'(o_empty[0]), 32'd1);
`ifndef FIFO_FWFT_EN
        check("t6.rst_dout", o_dout[0], 32'd0);
`endif
        check_all();
        #2;
        rst = 1'b0;
        cycle(1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
        check("t6.first_after_rst", o_dout[0], 32'hCAFE_F00D);
`endif
        cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
`ifndef FIFO_FWFT_EN
        check("t6.first_after_rst", o_dout[0], 32'hCAFE_F00D);
`endif
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
